// File: rtl/exc_redirect_ctrl_if.sv
// Fetch-side bundle between the redirect controller (master) and the fetch stage (slave).
// The controller observes the instruction bus handshake and drives redirects and the stale-data drop.
interface exc_redirect_ctrl_if;
    logic        inst_req;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        inst_data_drop;
    logic        fetch_allow;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    modport master (
        input  inst_req,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  redirect_ready,
        output inst_data_drop,
        output fetch_allow,
        output redirect_valid,
        output redirect_pc
    );

    modport slave (
        output inst_req,
        output inst_addr_ok,
        output inst_data_ok,
        output redirect_ready,
        input  inst_data_drop,
        input  fetch_allow,
        input  redirect_valid,
        input  redirect_pc
    );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// Exception/eret fetch redirect: one-cycle event latch, holds off under data stall, valid/ready to fetch,
// then drains stale in-flight fetches. Accepted-redirect counter only with REDIRECT_PERF_CNT_EN.
module exc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        memory_stall,
    output logic        flush,
    output logic [31:0] perf_redirects,
    exc_redirect_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] target_q;
    logic [1:0]  out_cnt;
    logic [1:0]  discard_cnt;
    logic        handshake;
    logic        flush_d;
    logic        fetch_inc;
    logic        fetch_dec;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an exception in ISSUE keeps us there so the new target is re-offered
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (exception || eret) begin
                    state_d = memory_stall ? HOLD : ISSUE;
                end
            end
            HOLD: begin
                if (!memory_stall) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake && !exception) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        handshake          = (state_q == ISSUE) && bus.redirect_ready;
        bus.redirect_valid = (state_q == ISSUE);
        bus.redirect_pc    = target_q;
        bus.fetch_allow    = (out_cnt != 2'd3) && (state_q == IDLE);
        bus.inst_data_drop = bus.inst_data_ok && ((discard_cnt != 2'd0) || (state_q != IDLE));
        flush_d            = ((state_d == ISSUE) && (state_q != ISSUE))
                          || ((state_q == ISSUE) && exception);
        fetch_inc          = bus.inst_req && bus.inst_addr_ok;
        fetch_dec          = bus.inst_data_ok && (out_cnt != 2'd0);
    end

    // Redirect target and flush pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            flush    <= 1'b0;
            target_q <= RESET_PC;
        end else begin
            flush <= flush_d;
            if (state_q == IDLE) begin
                if (exception) begin
                    target_q <= EXC_VECTOR;
                end else if (eret) begin
                    target_q <= epc;
                end
            end else if (exception) begin
                target_q <= EXC_VECTOR;
            end
        end
    end

    // Outstanding-fetch tracking; a simultaneous accept and return cancel out
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_cnt <= 2'd0;
        end else if (fetch_inc && !bus.inst_data_ok) begin
            if (out_cnt != 2'd3) begin
                out_cnt <= out_cnt + 2'd1;
            end
        end else if (fetch_dec && !fetch_inc) begin
            out_cnt <= out_cnt - 2'd1;
        end
    end

    // Every fetch still in flight at the redirect returns wrong-path data
    always_ff @(posedge clk) begin
        if (!resetn) begin
            discard_cnt <= 2'd0;
        end else if (handshake) begin
            discard_cnt <= out_cnt - {1'b0, fetch_dec};
        end else if (bus.inst_data_ok && (discard_cnt != 2'd0)) begin
            discard_cnt <= discard_cnt - 2'd1;
        end
    end

`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_q <= 32'd0;
        end else if (handshake) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_redirects = perf_q;
`else
    assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: inputs change 1 time unit after posedge, outputs checked there.
module tb_exc_redirect_ctrl;

`ifdef REDIRECT_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        exception;
    logic        eret;
    logic [31:0] epc;
    logic        memory_stall;
    logic        flush;
    logic [31:0] perf_redirects;
    int          checks = 0;
    int          errors = 0;

    exc_redirect_ctrl_if bus ();

    exc_redirect_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .exception      (exception),
        .eret           (eret),
        .epc            (epc),
        .memory_stall   (memory_stall),
        .flush          (flush),
        .perf_redirects (perf_redirects),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] perf_exp(input int n);
        return PERF_ON ? 32'(n) : 32'd0;
    endfunction

    initial begin
        resetn = 1'b0; exception = 1'b0; eret = 1'b0; epc = 32'd0; memory_stall = 1'b0;
        bus.inst_req = 1'b0; bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
        bus.redirect_ready = 1'b0;
        tick(); tick();
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_pc", bus.redirect_pc, 32'hbfc00000);
        chk("rst_perf", perf_redirects, 32'd0);
        chk("rst_fetch_allow", {31'd0, bus.fetch_allow}, 32'd1);
        resetn = 1'b1;
        tick();

        // Idle exception, fetch ready immediately
        exception = 1'b1; bus.redirect_ready = 1'b1;
        tick();
        exception = 1'b0;
        chk("idle_exc_flush", {31'd0, flush}, 32'd1);
        chk("idle_exc_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("idle_exc_pc", bus.redirect_pc, 32'hbfc00380);
        chk("idle_exc_fa", {31'd0, bus.fetch_allow}, 32'd0);
        tick();
        chk("idle_exc_flush_end", {31'd0, flush}, 32'd0);
        chk("idle_exc_back_idle", {31'd0, bus.redirect_valid}, 32'd0);
        chk("idle_exc_fa_back", {31'd0, bus.fetch_allow}, 32'd1);
        chk("perf_1", perf_redirects, perf_exp(1));

        // Eret under a 3-cycle stall
        eret = 1'b1; epc = 32'h80001234; memory_stall = 1'b1; bus.redirect_ready = 1'b0;
        tick();
        eret = 1'b0;
        chk("hold1_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("hold1_fa", {31'd0, bus.fetch_allow}, 32'd0);
        chk("hold1_flush", {31'd0, flush}, 32'd0);
        tick();
        chk("hold2_valid", {31'd0, bus.redirect_valid}, 32'd0);
        tick();
        chk("hold3_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("hold3_flush", {31'd0, flush}, 32'd0);
        memory_stall = 1'b0;
        tick();
        chk("eret_flush", {31'd0, flush}, 32'd1);
        chk("eret_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("eret_pc", bus.redirect_pc, 32'h80001234);
        tick();
        chk("eret_flush_once", {31'd0, flush}, 32'd0);
        chk("eret_valid_wait", {31'd0, bus.redirect_valid}, 32'd1);
        bus.redirect_ready = 1'b1;
        tick();
        chk("eret_done", {31'd0, bus.redirect_valid}, 32'd0);
        chk("perf_2", perf_redirects, perf_exp(2));

        // Simultaneous exception and eret
        exception = 1'b1; eret = 1'b1; epc = 32'h80001234; bus.redirect_ready = 1'b0;
        tick();
        exception = 1'b0; eret = 1'b0;
        chk("both_pc", bus.redirect_pc, 32'hbfc00380);
        chk("both_flush", {31'd0, flush}, 32'd1);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;

        // Override during ISSUE, eret ignored in ISSUE
        eret = 1'b1; epc = 32'h80005678;
        tick();
        eret = 1'b0;
        chk("ovr_eret_pc", bus.redirect_pc, 32'h80005678);
        tick();
        chk("ovr_flush_gap", {31'd0, flush}, 32'd0);
        exception = 1'b1;
        tick();
        exception = 1'b0;
        chk("ovr_pc", bus.redirect_pc, 32'hbfc00380);
        chk("ovr_reflush", {31'd0, flush}, 32'd1);
        chk("ovr_valid", {31'd0, bus.redirect_valid}, 32'd1);
        eret = 1'b1; epc = 32'h12345678;
        tick();
        eret = 1'b0;
        chk("ovr_eret_ignored", bus.redirect_pc, 32'hbfc00380);
        chk("ovr_flush_end", {31'd0, flush}, 32'd0);
        bus.redirect_ready = 1'b1;
        tick();
        chk("ovr_done", {31'd0, bus.redirect_valid}, 32'd0);
        chk("perf_4", perf_redirects, perf_exp(4));

        // Stale drain: two fetches outstanding at the handshake
        bus.inst_req = 1'b1; bus.inst_addr_ok = 1'b1;
        tick(); tick();
        bus.inst_req = 1'b0; bus.inst_addr_ok = 1'b0;
        exception = 1'b1;
        tick();
        exception = 1'b0;
        tick();
        chk("drain_idle", {31'd0, bus.redirect_valid}, 32'd0);
        bus.inst_data_ok = 1'b1;
        #1;
        chk("drain_drop1", {31'd0, bus.inst_data_drop}, 32'd1);
        tick();
        chk("drain_drop2", {31'd0, bus.inst_data_drop}, 32'd1);
        tick();
        chk("drain_drop3", {31'd0, bus.inst_data_drop}, 32'd0);
        bus.inst_data_ok = 1'b0;
        tick();
        chk("perf_5", perf_redirects, perf_exp(5));

        // Outstanding count saturation, cancel-out and no wrap below zero
        bus.inst_req = 1'b1; bus.inst_addr_ok = 1'b1;
        tick(); tick(); tick();
        bus.inst_req = 1'b0; bus.inst_addr_ok = 1'b0;
        chk("cnt3_fa", {31'd0, bus.fetch_allow}, 32'd0);
        bus.inst_data_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("cnt2_fa", {31'd0, bus.fetch_allow}, 32'd1);
        bus.inst_req = 1'b1; bus.inst_addr_ok = 1'b1; bus.inst_data_ok = 1'b1;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("cnt_both_fa", {31'd0, bus.fetch_allow}, 32'd1);
        tick();
        bus.inst_req = 1'b0; bus.inst_addr_ok = 1'b0;
        chk("cnt_back3_fa", {31'd0, bus.fetch_allow}, 32'd0);
        bus.inst_data_ok = 1'b1;
        #1;
        chk("idle_no_drop", {31'd0, bus.inst_data_drop}, 32'd0);
        tick(); tick(); tick(); tick();
        bus.inst_data_ok = 1'b0;
        chk("cnt_nowrap_fa", {31'd0, bus.fetch_allow}, 32'd1);

        // Data return while held off is stale
        exception = 1'b1; memory_stall = 1'b1; bus.redirect_ready = 1'b1;
        tick();
        exception = 1'b0;
        bus.inst_data_ok = 1'b1;
        #1;
        chk("hold_drop", {31'd0, bus.inst_data_drop}, 32'd1);
        bus.inst_data_ok = 1'b0; memory_stall = 1'b0;
        tick();
        chk("hold_exit_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("perf_6", perf_redirects, perf_exp(6));

        // Reset mid-ISSUE, with an exception in the same cycle
        exception = 1'b1; bus.redirect_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, bus.redirect_valid}, 32'd1);
        resetn = 1'b0;
        tick();
        exception = 1'b0;
        chk("mid_rst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("mid_rst_pc", bus.redirect_pc, 32'hbfc00000);
        chk("mid_rst_perf", perf_redirects, 32'd0);
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("post_rst_flush", {31'd0, flush}, 32'd0);
        chk("post_rst_valid", {31'd0, bus.redirect_valid}, 32'd0);
        chk("post_rst_fa", {31'd0, bus.fetch_allow}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
